// File: rtl/blackbox_sweeper.sv
// Clocked exhaustive sweep of a 3-input combinational block: applies all eight
// input vectors, samples the output of each, and compares the truth table to EXPECTED.
//
// state  | meaning
// IDLE   | waiting for start; last results held
// SETTLE | vector idx driven, waiting SETTLE cycles
// SAMPLE | vector idx still driven; dut_j captured at end of cycle
// DONE   | one-cycle completion; done pulses, pass valid
module blackbox_sweeper #(
  parameter int          SETTLE   = 1,
  parameter logic [7:0]  EXPECTED = 8'b1110_1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       dut_i,
  output logic       dut_h,
  output logic       dut_o,
  input  logic       dut_j,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic [3:0] mismatch_cnt,
  output logic       pass
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE_ST = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t     state, state_n;
  logic [2:0] idx, idx_n;
  logic [3:0] cnt, cnt_n;
  logic [7:0] table_n;
  logic [3:0] mm_n;
  logic       pass_n;
  logic [2:0] vec_n;
  logic       busy_n;
  logic       done_n;
  logic [3:0] mm_inc;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    table_n = table_out;
    mm_n    = mismatch_cnt;
    pass_n  = pass;
    mm_inc  = {3'd0, (dut_j != EXPECTED[idx])};

    case (state)
      IDLE: begin
        if (start) begin
          state_n = SETTLE_ST;
          idx_n   = 3'd0;
          cnt_n   = 4'd0;
          table_n = 8'd0;
          mm_n    = 4'd0;
          pass_n  = 1'b0;
        end
      end
      SETTLE_ST: begin
        if (cnt == SETTLE_LAST) state_n = SAMPLE;
        else                    cnt_n   = cnt + 4'd1;
      end
      SAMPLE: begin
        table_n[idx] = dut_j;
        mm_n         = mismatch_cnt + mm_inc;
        if (idx == 3'd7) begin
          state_n = DONE;
          // pass is registered on entry to DONE so it is valid alongside done
          pass_n  = (mm_n == 4'd0);
        end else begin
          idx_n   = idx + 3'd1;
          cnt_n   = 4'd0;
          state_n = SETTLE_ST;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    busy_n = (state_n == SETTLE_ST) || (state_n == SAMPLE);
    vec_n  = busy_n ? idx_n : 3'd0;
    done_n = (state_n == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= 3'd0;
      cnt          <= 4'd0;
      table_out    <= 8'd0;
      mismatch_cnt <= 4'd0;
      pass         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      dut_i        <= 1'b0;
      dut_h        <= 1'b0;
      dut_o        <= 1'b0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      cnt          <= cnt_n;
      table_out    <= table_n;
      mismatch_cnt <= mm_n;
      pass         <= pass_n;
      busy         <= busy_n;
      done         <= done_n;
      {dut_i, dut_h, dut_o} <= vec_n;
    end
  end

endmodule

// File: tb/tb_blackbox_sweeper.sv
// Bench for blackbox_sweeper: behavioural blackbox from a truth-table variable,
// expected results derived from popcount arithmetic and sweep-length formula.
module tb_blackbox_sweeper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s1_start = 1'b0, s3_start = 1'b0;
  logic d1_i, d1_h, d1_o, d1_j, d1_busy, d1_done, d1_pass;
  logic d3_i, d3_h, d3_o, d3_j, d3_busy, d3_done, d3_pass;
  logic [7:0] d1_tbl, d3_tbl;
  logic [3:0] d1_mm, d3_mm;
  logic [7:0] bb_tbl = 8'hE8;
  bit sel = 1'b0;
  int tests = 0, fails = 0;

  localparam logic [7:0] EXP = 8'hE8;

  always #5 clk = ~clk;

  assign d1_j = bb_tbl[{d1_i, d1_h, d1_o}];
  assign d3_j = bb_tbl[{d3_i, d3_h, d3_o}];

  blackbox_sweeper u_s1 (
    .clk(clk), .rst(rst), .start(s1_start),
    .dut_i(d1_i), .dut_h(d1_h), .dut_o(d1_o), .dut_j(d1_j),
    .busy(d1_busy), .done(d1_done), .table_out(d1_tbl),
    .mismatch_cnt(d1_mm), .pass(d1_pass)
  );

  blackbox_sweeper #(.SETTLE(3), .EXPECTED(8'hE8)) u_s3 (
    .clk(clk), .rst(rst), .start(s3_start),
    .dut_i(d3_i), .dut_h(d3_h), .dut_o(d3_o), .dut_j(d3_j),
    .busy(d3_busy), .done(d3_done), .table_out(d3_tbl),
    .mismatch_cnt(d3_mm), .pass(d3_pass)
  );

  // selected-instance views
  wire [2:0] m_vec  = sel ? {d3_i, d3_h, d3_o} : {d1_i, d1_h, d1_o};
  wire       m_busy = sel ? d3_busy : d1_busy;
  wire       m_done = sel ? d3_done : d1_done;
  wire [7:0] m_tbl  = sel ? d3_tbl  : d1_tbl;
  wire [3:0] m_mm   = sel ? d3_mm   : d1_mm;
  wire       m_pass = sel ? d3_pass : d1_pass;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_start(input logic v);
    if (sel) s3_start = v; else s1_start = v;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_vec"},  {29'd0, m_vec}, 0);
    check({tag, "_busy"}, {31'd0, m_busy}, 0);
    check({tag, "_done"}, {31'd0, m_done}, 0);
    check({tag, "_tbl"},  {24'd0, m_tbl}, 0);
    check({tag, "_mm"},   {28'd0, m_mm}, 0);
    check({tag, "_pass"}, {31'd0, m_pass}, 0);
  endtask

  // One full sweep on the selected instance with settle s and blackbox table tbl.
  task automatic sweep(input bit use3, input int s, input logic [7:0] tbl, input bit pulse_mid);
    int n, per, extra;
    bit seen;
    int exp_mm;
    sel = use3;
    bb_tbl = tbl;
    per = 8 * (s + 1);
    exp_mm = $countones(tbl ^ EXP);
    @(negedge clk); drive_start(1'b1);
    @(posedge clk);
    @(negedge clk); drive_start(1'b0);
    n = 0; seen = 0;
    while (!seen && n <= per + 4) begin
      if (m_done) seen = 1;
      else begin
        if (n < per) begin
          check("vec_seq", {29'd0, m_vec}, n / (s + 1));
          check("busy_hi", {31'd0, m_busy}, 1);
        end
        drive_start(pulse_mid && n == 5);
        @(posedge clk); @(negedge clk);
        n++;
      end
    end
    check("done_seen", {31'd0, seen}, 1);
    check("done_lat", n, per);
    check("busy_fall", {31'd0, m_busy}, 0);
    check("vec_done", {29'd0, m_vec}, 0);
    check("table", {24'd0, m_tbl}, {24'd0, tbl});
    check("mismatch", {28'd0, m_mm}, exp_mm);
    check("pass", {31'd0, m_pass}, (exp_mm == 0));
    extra = 0;
    for (int k = 0; k < per + 4; k++) begin
      @(posedge clk); @(negedge clk);
      if (m_done) extra++;
    end
    check("single_done", extra, 0);
    check("hold_table", {24'd0, m_tbl}, {24'd0, tbl});
    check("hold_pass", {31'd0, m_pass}, (exp_mm == 0));
  endtask

  initial begin
    int n, d1, d2;
    logic [7:0] r;
    bit ok;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    sel = 0; check_idle_outputs("reset_s1");
    sel = 1; check_idle_outputs("reset_s3");
    rst = 1'b0;

    sweep(0, 1, 8'hE8, 0);   // majority
    sweep(0, 1, 8'h00, 0);   // stuck at 0
    sweep(0, 1, 8'h17, 0);   // inverted majority: 8 mismatches
    sweep(1, 3, 8'hE8, 0);   // longer settle
    sweep(0, 1, 8'hE8, 1);   // start pulsed while busy
    for (int t = 0; t < 4; t++) begin
      r = 8'($urandom);
      sweep(t[0], t[0] ? 3 : 1, r, 0);
    end

    // start held high: back-to-back sweeps
    sel = 0; bb_tbl = 8'hE8;
    @(negedge clk); s1_start = 1'b1;
    @(posedge clk); @(negedge clk);
    n = 0; d1 = -1; d2 = -1;
    while (d2 < 0 && n < 60) begin
      if (d1_done) begin
        if (d1 < 0) d1 = n; else d2 = n;
      end
      if (n == 17) check("b2b_idle_gap", {31'd0, d1_busy}, 0);
      if (n == 18) check("b2b_restart", {31'd0, d1_busy}, 1);
      @(posedge clk); @(negedge clk);
      n++;
    end
    s1_start = 1'b0;
    check("b2b_done1", d1, 16);
    check("b2b_done2", d2, 34);
    check("b2b_pass", {31'd0, d1_pass}, 1);
    repeat (3) @(posedge clk);

    // reset at vector 4 aborts the sweep
    @(negedge clk); sel = 0; bb_tbl = 8'hE8; s1_start = 1'b1;
    @(posedge clk); @(negedge clk); s1_start = 1'b0;
    n = 0;
    while (n < 40 && d1_vec_not4()) begin
      @(posedge clk); @(negedge clk); n++;
    end
    check("reach_vec4", {29'd0, d1_i, d1_h, d1_o}, 4);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check_idle_outputs("abort");
    rst = 1'b0;
    ok = 1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); @(negedge clk);
      if (d1_done || d1_busy) ok = 0;
    end
    check("abort_quiet", {31'd0, ok}, 1);

    // rst and start together: rst wins
    @(negedge clk); rst = 1'b1; s1_start = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rst_wins_busy", {31'd0, d1_busy}, 0);
    check("rst_wins_vec", {29'd0, d1_i, d1_h, d1_o}, 0);
    rst = 1'b0; s1_start = 1'b0;

    sweep(0, 1, 8'hE8, 0);   // fresh sweep after abort

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  function automatic bit d1_vec_not4();
    return {d1_i, d1_h, d1_o} != 3'd4;
  endfunction

endmodule
